// File: rtl/pcpi_pkg.sv
// Shared PCPI definitions: FSM state type, custom-0 opcode and accelerator funct3 codes,
// and the default unclaimed-instruction timeout.
package pcpi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } pcpi_state_e;

   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   localparam logic [2:0] F3_SIGMA0 = 3'd0;
   localparam logic [2:0] F3_SIGMA1 = 3'd1;
   localparam logic [2:0] F3_SSIG0  = 3'd2;
   localparam logic [2:0] F3_SSIG1  = 3'd3;

   localparam int unsigned PCPI_DEFAULT_TIMEOUT = 16;

   function automatic logic is_custom0(input logic [31:0] insn);
      return insn[6:0] == OPC_CUSTOM0;
   endfunction

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// Counts consecutive un-waited ISSUE cycles; expired_o flags the cycle whose count
// reaches TIMEOUT_CYCLES so the initiator can leave ISSUE on that same edge.
module pcpi_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear_i,
   input  logic inc_i,
   input  logic wait_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         if (wait_i) begin
            cnt_d = '0;
         end else if (cnt_q < LIMIT) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = inc_i && !wait_i && (cnt_q >= LIMIT_M1);

endmodule

// File: rtl/pcpi_initiator.sv
// PCPI master: one request in flight, valid/ready request and response ports.
// Define PCPI_INIT_TIMEOUT_EN to add the unclaimed-instruction timeout and rsp_err path.
module pcpi_initiator
   import pcpi_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = PCPI_DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_insn,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_wr,
   output logic        rsp_err,
   output logic        pcpi_valid,
   output logic [31:0] pcpi_insn,
   output logic [31:0] pcpi_rs1,
   output logic [31:0] pcpi_rs2,
   input  logic        pcpi_wr,
   input  logic [31:0] pcpi_rd,
   input  logic        pcpi_wait,
   input  logic        pcpi_ready
);

   pcpi_state_e state_q;
   logic        req_ready_q;
   logic        pcpi_valid_q;
   logic [31:0] pcpi_insn_q;
   logic [31:0] pcpi_rs1_q;
   logic [31:0] pcpi_rs2_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_data_q;
   logic        rsp_wr_q;
   logic        rsp_err_q;
   logic        expired;

`ifdef PCPI_INIT_TIMEOUT_EN
   pcpi_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .resetn   (resetn),
      .clear_i  (state_q == IDLE),
      .inc_i    ((state_q == ISSUE) && !pcpi_ready),
      .wait_i   (pcpi_wait),
      .expired_o(expired)
   );
`else
   logic wait_unused;
   assign wait_unused = pcpi_wait;
   assign expired     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         pcpi_valid_q <= 1'b0;
         pcpi_insn_q  <= '0;
         pcpi_rs1_q   <= '0;
         pcpi_rs2_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_wr_q     <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  pcpi_insn_q  <= req_insn;
                  pcpi_rs1_q   <= req_rs1;
                  pcpi_rs2_q   <= req_rs2;
                  pcpi_valid_q <= 1'b1;
                  req_ready_q  <= 1'b0;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               // ready is checked first so it wins over a coincident timeout
               if (pcpi_ready) begin
                  rsp_data_q   <= pcpi_rd;
                  rsp_wr_q     <= pcpi_wr;
                  rsp_err_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  pcpi_valid_q <= 1'b0;
                  state_q      <= RESP;
               end else if (expired) begin
                  rsp_data_q   <= '0;
                  rsp_wr_q     <= 1'b0;
                  rsp_err_q    <= 1'b1;
                  rsp_valid_q  <= 1'b1;
                  pcpi_valid_q <= 1'b0;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign pcpi_valid = pcpi_valid_q;
   assign pcpi_insn  = pcpi_insn_q;
   assign pcpi_rs1   = pcpi_rs1_q;
   assign pcpi_rs2   = pcpi_rs2_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_wr     = rsp_wr_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_pcpi_initiator.sv
// Bench for pcpi_initiator: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations. Follows PCPI_INIT_TIMEOUT_EN.
module tb_pcpi_initiator;
   import pcpi_pkg::*;

   localparam int unsigned T = 16;
`ifdef PCPI_INIT_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_insn;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_wr;
   logic        rsp_err;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic [31:0] pcpi_rs1;
   logic [31:0] pcpi_rs2;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;

   int cmp_cnt = 0;
   int fail_cnt = 0;

   always #5 clk = ~clk;

   pcpi_initiator #(.TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_insn  (req_insn),
      .req_rs1   (req_rs1),
      .req_rs2   (req_rs2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_wr    (rsp_wr),
      .rsp_err   (rsp_err),
      .pcpi_valid(pcpi_valid),
      .pcpi_insn (pcpi_insn),
      .pcpi_rs1  (pcpi_rs1),
      .pcpi_rs2  (pcpi_rs2),
      .pcpi_wr   (pcpi_wr),
      .pcpi_rd   (pcpi_rd),
      .pcpi_wait (pcpi_wait),
      .pcpi_ready(pcpi_ready)
   );

   // Responder: mode 0 silent, 1 combinational Sigma0, 2 waits wait_len cycles then returns DEADBEEF
   int mode;
   int wait_len;
   int vc;

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   always @(posedge clk) begin
      if (!pcpi_valid) vc <= 0;
      else             vc <= vc + 1;
   end

   assign pcpi_ready = pcpi_valid &&
                       ((mode == 1 && pcpi_insn[6:0] == OPC_CUSTOM0) || (mode == 2 && vc >= wait_len));
   assign pcpi_wait  = pcpi_valid && mode == 2 && vc < wait_len;
   assign pcpi_rd    = (mode == 1) ? big_sigma0(pcpi_rs1) : 32'hDEADBEEF;
   assign pcpi_wr    = (mode == 1);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one op in flight, tracked as busy / response-pending
   bit          m_known = 1'b0;
   bit          m_busy, m_rsp;
   int          m_cnt;
   logic [31:0] m_insn, m_rs1, m_rs2, m_data;
   logic        m_wr, m_err;

   always @(posedge clk) begin
      if (!resetn) begin
         m_known <= 1'b1;
         m_busy <= 1'b0; m_rsp <= 1'b0; m_cnt <= 0;
         m_insn <= '0; m_rs1 <= '0; m_rs2 <= '0;
         m_data <= '0; m_wr <= 1'b0; m_err <= 1'b0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy <= 1'b1; m_cnt <= 0;
            m_insn <= req_insn; m_rs1 <= req_rs1; m_rs2 <= req_rs2;
         end
      end else if (!m_rsp) begin
         if (pcpi_ready) begin
            m_rsp <= 1'b1; m_data <= pcpi_rd; m_wr <= pcpi_wr; m_err <= 1'b0;
         end else if (TMO_EN) begin
            if (pcpi_wait) m_cnt <= 0;
            else if (m_cnt + 1 >= int'(T)) begin
               m_rsp <= 1'b1; m_data <= '0; m_wr <= 1'b0; m_err <= 1'b1;
            end else m_cnt <= m_cnt + 1;
         end
      end else if (rsp_ready) begin
         m_busy <= 1'b0; m_rsp <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_known) begin
         check("m_req_ready",  {31'd0, req_ready},  {31'd0, !m_busy});
         check("m_pcpi_valid", {31'd0, pcpi_valid}, {31'd0, m_busy && !m_rsp});
         check("m_pcpi_insn",  pcpi_insn, m_insn);
         check("m_pcpi_rs1",   pcpi_rs1,  m_rs1);
         check("m_pcpi_rs2",   pcpi_rs2,  m_rs2);
         check("m_rsp_valid",  {31'd0, rsp_valid},  {31'd0, m_rsp});
         check("m_rsp_data",   rsp_data,  m_data);
         check("m_rsp_wr",     {31'd0, rsp_wr},  {31'd0, m_wr});
         check("m_rsp_err",    {31'd0, rsp_err}, {31'd0, m_err});
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Presents a request for one edge; returns in cycle 1 after acceptance
   task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
      req_valid = 1'b1; req_insn = insn; req_rs1 = rs1; req_rs2 = rs2;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      int cyc;
      bit seen;
      resetn = 1'b0; mode = 0; wait_len = 0;
      req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0; rsp_ready = 1'b0;
      repeat (2) begin
         req_valid = 1'($urandom); req_insn = $urandom; req_rs1 = $urandom;
         req_rs2 = $urandom; rsp_ready = 1'($urandom);
         tick();
      end
      resetn = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
      check("rst_req_ready",  {31'd0, req_ready},  32'd1);
      check("rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
      check("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
      check("rst_rsp_data",   rsp_data,  32'd0);
      check("rst_pcpi_insn",  pcpi_insn, 32'd0);
      tick();

      // Single op, combinational Sigma0
      mode = 1;
      issue(32'h0000000B, 32'h00000001, 32'h0);
      check("op_c1_pcpi_valid", {31'd0, pcpi_valid}, 32'd1);
      check("op_c1_req_ready",  {31'd0, req_ready},  32'd0);
      tick();
      check("op_c2_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
      check("op_c2_rsp_valid",  {31'd0, rsp_valid},  32'd1);
      check("op_c2_rsp_data",   rsp_data, 32'h40080400);
      check("op_c2_rsp_wr",     {31'd0, rsp_wr},  32'd1);
      check("op_c2_rsp_err",    {31'd0, rsp_err}, 32'd0);
      tick();
      check("op_c3_req_ready",  {31'd0, req_ready}, 32'd1);
      check("op_c3_rsp_valid",  {31'd0, rsp_valid}, 32'd0);

      // Backpressure
      rsp_ready = 1'b0;
      issue(32'h0000000B, 32'h00000002, 32'h0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid",  {31'd0, rsp_valid},  32'd1);
         check("bp_rsp_data",   rsp_data, 32'h80100800);
         check("bp_req_ready",  {31'd0, req_ready},  32'd0);
         check("bp_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("bp_done_req_ready", {31'd0, req_ready}, 32'd1);

      // Wait stretch of 40 cycles
      mode = 2; wait_len = 40;
      issue(32'h0000200B, 32'h12345678, 32'h9ABCDEF0);
      cyc = 0;
      while (!rsp_valid && cyc < 200) begin
         cyc++;
         tick();
      end
      check("ws_pcpi_cycles", cyc, 32'd41);
      check("ws_rsp_data", rsp_data, 32'hDEADBEEF);
      check("ws_rsp_err",  {31'd0, rsp_err}, 32'd0);
      tick();

      // Unclaimed op against a silent responder
      mode = 0;
      issue(32'h00000033, 32'h11111111, 32'h22222222);
      if (TMO_EN) begin
         cyc = 0;
         while (!rsp_valid && cyc < 100) begin
            if (pcpi_valid) cyc++;
            tick();
         end
         check("to_pcpi_cycles", cyc, T);
         check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("to_rsp_err",   {31'd0, rsp_err},   32'd1);
         check("to_rsp_data",  rsp_data, 32'd0);
         check("to_rsp_wr",    {31'd0, rsp_wr},    32'd0);
         tick();
         issue(32'h00000033, 32'h0, 32'h0);
         tick();
      end else begin
         seen = 1'b0;
         repeat (100) begin
            if (rsp_valid) seen = 1'b1;
            tick();
         end
         check("nto_pcpi_valid", {31'd0, pcpi_valid}, 32'd1);
         check("nto_no_rsp",     {31'd0, seen},       32'd0);
      end

      // Reset in the middle of ISSUE, then a clean op
      resetn = 1'b0;
      tick();
      check("rmid_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
      check("rmid_rsp_valid",  {31'd0, rsp_valid},  32'd0);
      resetn = 1'b1;
      mode = 1;
      issue(32'h0000000B, 32'h80000000, 32'h0);
      tick();
      check("rmid_next_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rmid_next_rsp_data",  rsp_data, 32'h20040200);
      tick();
      check("rmid_next_req_ready", {31'd0, req_ready}, 32'd1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
